// File: rtl/multicycle_ctrl_if.sv
// Port bundle between the multicycle sequencer (master) and the RV64I datapath (slave).
// mem_read_o/mem_write_o act as "valid": held high until the cycle mem_ready_i is 1, which completes the access.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_i;
  logic [31:0]      instr_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             ir_write_o;
  logic             pc_write_o;
  logic             pc_sel_o;
  logic             reg_write_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             alu_src_o;
  logic             mem_to_reg_o;
  logic [1:0]       alu_op_o;
  logic             busy_o;
  logic             halted_o;
  logic [1:0]       err_o;
  logic [CNT_W-1:0] instret_o;
  logic [2:0]       state_dbg;

  modport master (
    input  run_i, instr_i, zero_i, mem_ready_i,
    output ir_write_o, pc_write_o, pc_sel_o, reg_write_o, mem_read_o, mem_write_o,
           alu_src_o, mem_to_reg_o, alu_op_o, busy_o, halted_o, err_o, instret_o, state_dbg
  );

  modport slave (
    output run_i, instr_i, zero_i, mem_ready_i,
    input  ir_write_o, pc_write_o, pc_sel_o, reg_write_o, mem_read_o, mem_write_o,
           alu_src_o, mem_to_reg_o, alu_op_o, busy_o, halted_o, err_o, instret_o, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH->DECODE->EXEC->MEM->WB sequencer for the RV64I datapath with
// memory wait states, run/stop control, error halt and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int OPCODE_W    = 7,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LD   = 3'd3,
    C_ST   = 3'd4,
    C_BEQ  = 3'd5
  } cls_t;

  localparam int                    WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [OPCODE_W-1:0]   OP_R      = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0]   OP_I      = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0]   OP_LD     = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0]   OP_ST     = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0]   OP_BEQ    = OPCODE_W'(7'b1100011);

  state_t              state;
  cls_t                cls;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    instret;
  logic [1:0]          err;
  logic [OPCODE_W-1:0] opcode;
  logic                retire;
  logic                unused_instr;

  assign opcode       = bus.instr_i[OPCODE_W-1:0];
  assign unused_instr = ^bus.instr_i[31:OPCODE_W];

  // The cycle that issues the instruction's single pc_write pulse.
  assign retire = (state == S_EXEC && cls == C_BEQ) ||
                  (state == S_MEM  && cls == C_ST && bus.mem_ready_i) ||
                  (state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cls      <= C_NONE;
      wait_cnt <= '0;
      instret  <= '0;
      err      <= 2'b00;
    end else begin
      case (state)
        S_IDLE:   if (bus.run_i) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          state <= S_EXEC;
          case (opcode)
            OP_R:    cls <= C_R;
            OP_I:    cls <= C_I;
            OP_LD:   cls <= C_LD;
            OP_ST:   cls <= C_ST;
            OP_BEQ:  cls <= C_BEQ;
            default: begin
              cls   <= C_NONE;
              state <= S_HALT;
              err   <= 2'b01;
            end
          endcase
        end
        S_EXEC: begin
          if (cls == C_R || cls == C_I) begin
            state <= S_WB;
          end else if (cls == C_LD || cls == C_ST) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end
        end
        S_MEM: begin
          if (bus.mem_ready_i) begin
            if (cls == C_LD) state <= S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_HALT;
            err   <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB:     state <= S_WB;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
      // run_i is only honoured at an instruction boundary.
      if (retire) begin
        instret <= instret + CNT_W'(1);
        state   <= bus.run_i ? S_FETCH : S_IDLE;
      end
    end
  end

  always_comb begin
    bus.ir_write_o   = 1'b0;
    bus.pc_write_o   = 1'b0;
    bus.pc_sel_o     = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.alu_src_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.alu_op_o     = 2'b00;
    case (state)
      S_FETCH: bus.ir_write_o = 1'b1;
      S_EXEC: begin
        if (cls == C_R || cls == C_I) bus.alu_op_o = 2'b10;
        else if (cls == C_BEQ)        bus.alu_op_o = 2'b01;
        bus.alu_src_o = (cls == C_I || cls == C_LD || cls == C_ST);
        if (cls == C_BEQ) begin
          bus.pc_write_o = 1'b1;
          bus.pc_sel_o   = bus.zero_i;
        end
      end
      S_MEM: begin
        bus.mem_read_o  = (cls == C_LD);
        bus.mem_write_o = (cls == C_ST);
        bus.alu_src_o   = 1'b1;
        bus.pc_write_o  = (cls == C_ST) && bus.mem_ready_i;
      end
      S_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = (cls == C_LD);
        bus.pc_write_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy_o    = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted_o  = (state == S_HALT);
  assign bus.err_o     = err;
  assign bus.instret_o = instret;
  assign bus.state_dbg = state;
endmodule
